// File: rtl/vending_multi.sv
// Multi-slot vending controller: coin credit, per-slot price/stock, single-cycle
// dispense and greedy one-coin-per-cycle change return.
module vending_multi #(
   parameter int NUM_SLOTS  = 8,
   parameter int IDX_W      = 3,
   parameter int CENT_W     = 10,
   parameter int STOCK_W    = 4,
   parameter int MAX_CREDIT = 995
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_SLOTS*CENT_W-1:0] price_tbl,
   input  logic                        restock,
   input  logic [IDX_W-1:0]            restock_index,
   input  logic [STOCK_W-1:0]          restock_count,
   input  logic [IDX_W-1:0]            index,
   input  logic                        select,
   input  logic                        nickel,
   input  logic                        dime,
   input  logic                        quarter,
   input  logic                        cancel,
   output logic [CENT_W-1:0]           credit,
   output logic                        dispensed,
   output logic [IDX_W-1:0]            dispensedIndex,
   output logic [1:0]                  change,
   output logic                        busy,
   output logic                        sold_out,
   output logic                        short_funds,
   output logic                        coin_reject
);

   typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

   state_t                             state_q;
   logic [CENT_W-1:0]                  credit_q;
   logic                               dispensed_q, busy_q, sold_q, short_q, rej_q;
   logic [IDX_W-1:0]                   didx_q;
   logic [1:0]                         change_q;
   logic [NUM_SLOTS-1:0][STOCK_W-1:0]  stock_q;

   logic [CENT_W:0]   coin_sum, acc_d;
   logic [CENT_W-1:0] credit_acc_d, sel_price_d, rem_d;
   logic [STOCK_W-1:0] sel_stock_d;
   logic              any_coin, ovf, sel_hit, sel_ok, idle_like, cancel_ok, buy;

   function automatic logic [1:0] pick_coin(input logic [CENT_W-1:0] c);
      if (c >= CENT_W'(25)) return 2'b11;
      if (c >= CENT_W'(10)) return 2'b10;
      if (c >= CENT_W'(5))  return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [CENT_W-1:0] coin_val(input logic [1:0] code);
      case (code)
         2'b11:   return CENT_W'(25);
         2'b10:   return CENT_W'(10);
         2'b01:   return CENT_W'(5);
         default: return '0;
      endcase
   endfunction

   always_comb begin
      coin_sum = '0;
      if (nickel)  coin_sum = coin_sum + (CENT_W+1)'(5);
      if (dime)    coin_sum = coin_sum + (CENT_W+1)'(10);
      if (quarter) coin_sum = coin_sum + (CENT_W+1)'(25);
      any_coin     = nickel | dime | quarter;
      acc_d        = {1'b0, credit_q} + coin_sum;
      ovf          = acc_d > (CENT_W+1)'(MAX_CREDIT);
      credit_acc_d = ovf ? credit_q : acc_d[CENT_W-1:0];
      sel_price_d  = '0;
      sel_stock_d  = '0;
      sel_hit      = 1'b0;
      // Loop lookup keeps out-of-range indices from ever addressing the tables.
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (index == IDX_W'(i)) begin
            sel_hit     = 1'b1;
            sel_price_d = price_tbl[i*CENT_W +: CENT_W];
            sel_stock_d = stock_q[i];
         end
      end
      idle_like = (state_q == IDLE) || (state_q == CREDIT);
      cancel_ok = cancel && (state_q == CREDIT);
      sel_ok    = sel_hit && (sel_price_d != '0) && (sel_stock_d != '0);
      buy       = idle_like && select && !cancel_ok && sel_ok && (credit_q >= sel_price_d);
      // A sub-nickel remainder (odd price) cannot be refunded and is dropped.
      rem_d     = (change_q == 2'b00) ? '0 : credit_q - coin_val(change_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stock_q <= '0;
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (restock && restock_index == IDX_W'(i))
               stock_q[i] <= restock_count;
            else if (buy && index == IDX_W'(i))
               stock_q[i] <= stock_q[i] - STOCK_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         credit_q    <= '0;
         dispensed_q <= 1'b0;
         didx_q      <= '0;
         change_q    <= 2'b00;
         busy_q      <= 1'b0;
         sold_q      <= 1'b0;
         short_q     <= 1'b0;
         rej_q       <= 1'b0;
      end else begin
         dispensed_q <= 1'b0;
         sold_q      <= 1'b0;
         short_q     <= 1'b0;
         rej_q       <= 1'b0;
         change_q    <= 2'b00;
         busy_q      <= 1'b0;
         case (state_q)
            IDLE, CREDIT: begin
               rej_q <= ovf;
               if (cancel_ok) begin
                  state_q  <= CHANGE;
                  credit_q <= credit_acc_d;
                  change_q <= pick_coin(credit_acc_d);
                  busy_q   <= 1'b1;
               end else if (buy) begin
                  state_q     <= DISPENSE;
                  credit_q    <= credit_acc_d - sel_price_d;
                  dispensed_q <= 1'b1;
                  didx_q      <= index;
                  busy_q      <= 1'b1;
               end else begin
                  sold_q   <= select && !sel_ok;
                  short_q  <= select && sel_ok;
                  credit_q <= credit_acc_d;
                  state_q  <= (credit_acc_d != '0) ? CREDIT : IDLE;
               end
            end
            DISPENSE: begin
               rej_q    <= any_coin;
               state_q  <= (credit_q != '0) ? CHANGE : IDLE;
               change_q <= pick_coin(credit_q);
               busy_q   <= credit_q != '0;
            end
            CHANGE: begin
               rej_q    <= any_coin;
               credit_q <= rem_d;
               if (rem_d == '0) begin
                  state_q <= IDLE;
               end else begin
                  change_q <= pick_coin(rem_d);
                  busy_q   <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign credit         = credit_q;
   assign dispensed      = dispensed_q;
   assign dispensedIndex = didx_q;
   assign change         = change_q;
   assign busy           = busy_q;
   assign sold_out       = sold_q;
   assign short_funds    = short_q;
   assign coin_reject    = rej_q;

endmodule

// File: tb/tb_vending_multi.sv
// Bench for vending_multi: directed vector table, hand-written corner sequences,
// then random traffic against a queue-based behavioural model.
module tb_vending_multi;
   localparam int NS = 8, IW = 3, CW = 10, SW = 4, MAXC = 995;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst = 1'b1, restock = 0, select = 0, nickel = 0, dime = 0, quarter = 0, cancel = 0;
   logic [NS*CW-1:0]  price_tbl;
   logic [IW-1:0]     restock_index = '0, index = '0;
   logic [SW-1:0]     restock_count = '0;
   logic [CW-1:0]     credit;
   logic              dispensed, busy, sold_out, short_funds, coin_reject;
   logic [IW-1:0]     dispensedIndex;
   logic [1:0]        change;

   vending_multi #(.NUM_SLOTS(NS), .IDX_W(IW), .CENT_W(CW), .STOCK_W(SW), .MAX_CREDIT(MAXC)) dut (
      .clk(clk), .rst(rst), .price_tbl(price_tbl), .restock(restock),
      .restock_index(restock_index), .restock_count(restock_count), .index(index),
      .select(select), .nickel(nickel), .dime(dime), .quarter(quarter), .cancel(cancel),
      .credit(credit), .dispensed(dispensed), .dispensedIndex(dispensedIndex),
      .change(change), .busy(busy), .sold_out(sold_out), .short_funds(short_funds),
      .coin_reject(coin_reject));

   typedef struct {int credit, disp, didx, chg, busy, sold, shrt, rej;} exp_t;
   typedef struct {bit rst, nk, dm, qt, sel, can, rs; int idx, ri, rc; exp_t e;} vec_t;

   int prices[NS] = '{50, 75, 150, 25, 200, 0, 65, 995};
   int n_cmp = 0, n_bad = 0;

   // behavioural model: credit value, stock array, refund coin queue
   int   m_credit = 0, m_didx = 0;
   int   m_stock[NS];
   bit   m_disp = 0;
   int   m_q[$];
   exp_t m_e;
   vec_t vecs[$];

   function automatic int cval(input int code);
      return (code == 3) ? 25 : (code == 2) ? 10 : (code == 1) ? 5 : 0;
   endfunction

   task automatic refund(input int c);
      int left = c;
      m_q.delete();
      while (left >= 5) begin
         if (left >= 25) begin m_q.push_back(3); left -= 25; end
         else if (left >= 10) begin m_q.push_back(2); left -= 10; end
         else begin m_q.push_back(1); left -= 5; end
      end
   endtask

   task automatic model_step();
      int sum, newc, p;
      bit anyc;
      m_e.disp = 0; m_e.sold = 0; m_e.shrt = 0; m_e.rej = 0;
      if (rst) begin
         m_credit = 0; m_didx = 0; m_disp = 0; m_q.delete();
         foreach (m_stock[i]) m_stock[i] = 0;
      end else begin
         anyc = nickel | dime | quarter;
         sum  = 5*int'(nickel) + 10*int'(dime) + 25*int'(quarter);
         if (m_disp) begin
            m_e.rej = anyc; m_disp = 0; refund(m_credit);
         end else if (m_q.size() > 0) begin
            m_e.rej = anyc; m_credit -= cval(m_q.pop_front());
         end else begin
            newc = (m_credit + sum > MAXC) ? m_credit : m_credit + sum;
            m_e.rej = (m_credit + sum > MAXC);
            if (cancel && m_credit > 0) begin
               m_credit = newc; refund(newc);
            end else if (select) begin
               p = prices[index];
               if (p == 0 || m_stock[index] == 0) begin m_e.sold = 1; m_credit = newc; end
               else if (m_credit < p) begin m_e.shrt = 1; m_credit = newc; end
               else begin
                  m_credit = newc - p; m_disp = 1; m_e.disp = 1; m_didx = int'(index);
                  m_stock[index]--;
               end
            end else m_credit = newc;
         end
         if (restock) m_stock[restock_index] = int'(restock_count);
      end
      m_e.credit = m_credit; m_e.didx = m_didx;
      m_e.chg  = (m_q.size() > 0) ? m_q[0] : 0;
      m_e.busy = m_disp || (m_q.size() > 0);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic cmp_out(input string tag, input exp_t e);
      chk({tag, ".credit"}, int'(credit), e.credit);
      chk({tag, ".dispensed"}, int'(dispensed), e.disp);
      chk({tag, ".dispensedIndex"}, int'(dispensedIndex), e.didx);
      chk({tag, ".change"}, int'(change), e.chg);
      chk({tag, ".busy"}, int'(busy), e.busy);
      chk({tag, ".sold_out"}, int'(sold_out), e.sold);
      chk({tag, ".short_funds"}, int'(short_funds), e.shrt);
      chk({tag, ".coin_reject"}, int'(coin_reject), e.rej);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_in(input bit n, d, q, s, c, input int idx);
      rst = 0; restock = 0; nickel = n; dime = d; quarter = q; select = s; cancel = c;
      index = IW'(idx);
   endtask

   task automatic hcyc(input string tag);
      cyc();
      cmp_out(tag, m_e);
      set_in(0, 0, 0, 0, 0, 0);
   endtask

   task automatic add(input bit r, n, d, q, s, c, input int idx, input bit rs, input int ri, rc,
                      input int cr, di, dx, ch, bz, so, sh, rj);
      vec_t v;
      v.rst = r; v.nk = n; v.dm = d; v.qt = q; v.sel = s; v.can = c; v.idx = idx;
      v.rs = rs; v.ri = ri; v.rc = rc;
      v.e.credit = cr; v.e.disp = di; v.e.didx = dx; v.e.chg = ch; v.e.busy = bz;
      v.e.sold = so; v.e.shrt = sh; v.e.rej = rj;
      vecs.push_back(v);
   endtask

   initial begin
      int r;
      foreach (prices[i]) price_tbl[i*CW +: CW] = CW'(prices[i]);
      foreach (m_stock[i]) m_stock[i] = 0;

      // --- directed vector table ---
      add(1,0,0,0,0,0,0, 0,0,0,  0,0,0,0,0,0,0,0);
      add(0,0,0,0,0,0,0, 1,2,3,  0,0,0,0,0,0,0,0);
      for (int k = 1; k <= 4; k++) add(0,1,0,0,0,0,0, 0,0,0, 5*k,0,0,0,0,0,0,0);
      add(0,0,0,0,1,0,2, 0,0,0, 20,0,0,0,0,0,1,0);
      for (int k = 1; k <= 6; k++) add(0,0,0,1,0,0,0, 0,0,0, 20+25*k,0,0,0,0,0,0,0);
      add(0,0,0,0,1,0,2, 0,0,0, 20,1,2,0,1,0,0,0);
      add(0,0,0,0,0,0,0, 0,0,0, 20,0,2,2,1,0,0,0);
      add(0,0,0,0,0,0,0, 0,0,0, 10,0,2,2,1,0,0,0);
      add(0,0,0,0,0,0,0, 0,0,0,  0,0,2,0,0,0,0,0);
      add(0,0,0,0,1,0,5, 0,0,0,  0,0,2,0,0,1,0,0);
      add(0,0,0,1,0,0,0, 0,0,0, 25,0,2,0,0,0,0,0);
      add(0,0,0,0,1,0,4, 0,0,0, 25,0,2,0,0,1,0,0);
      add(0,0,0,0,1,1,3, 0,0,0, 25,0,2,3,1,0,0,0);
      add(0,0,0,0,0,0,0, 0,0,0,  0,0,2,0,0,0,0,0);
      // slot 2 now holds 2: two more buys succeed, the third is sold out
      for (int rnd = 0; rnd < 2; rnd++) begin
         for (int k = 1; k <= 6; k++) add(0,0,0,1,0,0,0, 0,0,0, 25*k,0,2,0,0,0,0,0);
         add(0,0,0,0,1,0,2, 0,0,0, 0,1,2,0,1,0,0,0);
         add(0,0,0,0,0,0,0, 0,0,0, 0,0,2,0,0,0,0,0);
      end
      add(0,0,0,1,0,0,0, 0,0,0, 25,0,2,0,0,0,0,0);
      add(0,0,0,0,1,0,2, 0,0,0, 25,0,2,0,0,1,0,0);
      add(0,0,0,0,0,1,0, 0,0,0, 25,0,2,3,1,0,0,0);
      add(0,0,0,0,0,0,0, 0,0,0,  0,0,2,0,0,0,0,0);

      foreach (vecs[i]) begin
         rst = vecs[i].rst; nickel = vecs[i].nk; dime = vecs[i].dm; quarter = vecs[i].qt;
         select = vecs[i].sel; cancel = vecs[i].can; index = IW'(vecs[i].idx);
         restock = vecs[i].rs; restock_index = IW'(vecs[i].ri); restock_count = SW'(vecs[i].rc);
         cyc();
         cmp_out($sformatf("vec%0d", i), vecs[i].e);
      end
      set_in(0, 0, 0, 0, 0, 0);

      // --- credit ceiling: 985 then nickel+dime rejected, nickel accepted ---
      for (int k = 0; k < 39; k++) begin set_in(0, 0, 1, 0, 0, 0); hcyc("fill"); end
      set_in(0, 1, 0, 0, 0, 0); hcyc("fill");
      chk("ceil_985", int'(credit), 985);
      set_in(1, 1, 0, 0, 0, 0); hcyc("ovf");
      chk("ovf_reject", int'(coin_reject), 1);
      chk("ovf_credit", int'(credit), 985);
      set_in(1, 0, 0, 0, 0, 0); hcyc("nick");
      chk("ceil_990", int'(credit), 990);
      set_in(0, 0, 0, 0, 1, 0); hcyc("drain");
      for (int k = 0; k < 60 && busy; k++) hcyc("drain");
      chk("drain_idle", int'(busy), 0);

      // --- credit 40, cancel+select together: refund 25,10,5 ---
      set_in(1, 1, 1, 0, 0, 0); hcyc("c40");
      chk("c40_credit", int'(credit), 40);
      set_in(0, 0, 0, 1, 1, 3); hcyc("cxs");
      chk("cxs_nodisp", int'(dispensed), 0);
      chk("cxs_ch1", int'(change), 3);
      hcyc("cxs"); chk("cxs_ch2", int'(change), 2);
      hcyc("cxs"); chk("cxs_ch3", int'(change), 1);
      hcyc("cxs"); chk("cxs_end", int'(credit), 0); chk("cxs_busy", int'(busy), 0);

      // --- reset mid-refund, then restock colliding with a dispense ---
      set_in(0, 1, 1, 0, 0, 0); hcyc("c35");
      set_in(0, 0, 0, 0, 1, 0); hcyc("c35");
      chk("c35_chg", int'(change), 3);
      rst = 1; hcyc("rstchg");
      chk("rst_credit", int'(credit), 0);
      chk("rst_change", int'(change), 0);
      set_in(0, 0, 0, 0, 0, 0); restock = 1; restock_index = 3; restock_count = 2; hcyc("rs");
      set_in(0, 0, 1, 0, 0, 0); hcyc("rs");
      set_in(0, 0, 0, 1, 0, 3); restock = 1; restock_count = 7; hcyc("rsdisp");
      chk("rsdisp_disp", int'(dispensed), 1);
      hcyc("rsdisp");
      for (int k = 0; k < 7; k++) begin
         set_in(0, 0, 1, 0, 0, 0); hcyc("stk7");
         set_in(0, 0, 0, 1, 0, 3); hcyc("stk7");
         hcyc("stk7");
      end
      set_in(0, 0, 1, 0, 0, 0); hcyc("stk0");
      set_in(0, 0, 0, 1, 0, 3); hcyc("stk0");
      chk("stk7_sold", int'(sold_out), 1);

      // --- randomized traffic against the model ---
      for (int k = 0; k < 3000; k++) begin
         r = int'($urandom_range(0, 99));
         rst     = (r == 0);
         nickel  = ($urandom_range(0, 9) < 2);
         dime    = ($urandom_range(0, 9) < 2);
         quarter = ($urandom_range(0, 9) < 3);
         select  = ($urandom_range(0, 9) < 2);
         cancel  = ($urandom_range(0, 19) == 0);
         index   = IW'($urandom_range(0, NS-1));
         restock = ($urandom_range(0, 19) == 0);
         restock_index = IW'($urandom_range(0, NS-1));
         restock_count = SW'($urandom_range(0, 15));
         cyc();
         cmp_out($sformatf("rnd%0d", k), m_e);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
